ram_bist: RTL and testbench

- Parametrised successor to the fixed-size dual-port RAM test block used on the EPP board.
- Contains a simple dual-port RAM. Port A is write-only and port B is read-only, both synchronous.
- A built-in FSM fills the RAM with a selectable pattern, reads it back, compares every word and reports pass/fail, error count and first failing address.
- Sits between the EPP register file (start/mode/inject controls) and status readback.

---
 rtl/ram_bist.sv | 127 ++++++++++++
 tb/tb_ram_bist.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// Simple dual-port RAM with a built-in self-test FSM: fills a pattern, reads it back,
// and reports pass/fail, mismatch count and lowest failing address.
module ram_bist #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inject_en,
    input  logic [ADDR_W-1:0] inject_addr,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, WRITE, READ, CHECK, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [1:0]        mode_q;
    logic              inj_q;
    logic [ADDR_W-1:0] inj_addr_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              mismatch;
    logic [DATA_W-1:0] wr_word;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] p;
        int unsigned       idx;
        p = '0;
        case (m)
            2'd0: for (int unsigned b = 0; b < DATA_W; b++) if (b < ADDR_W) p[b] = a[b % ADDR_W];
            2'd1: begin
                for (int unsigned b = 0; b < DATA_W; b++) if (b < ADDR_W) p[b] = a[b % ADDR_W];
                p = ~p;
            end
            2'd2: for (int unsigned b = 0; b < DATA_W; b++) p[b] = (b[0] == a[0]);
            default: begin
                idx = 32'(a) % 32'(DATA_W);
                p[idx] = 1'b1;
            end
        endcase
        return p;
    endfunction

    assign accept   = start && (state == IDLE || state == DONE);
    assign mismatch = rd_valid && (dout_b != pattern(mode_q, rd_addr));
    assign wr_word  = pattern(mode_q, addr) ^ {{(DATA_W-1){1'b0}}, (inj_q && addr == inj_addr_q)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = WRITE;
            WRITE:      if (addr == LAST) state_next = READ;
            READ:       if (addr == LAST) state_next = CHECK;
            CHECK:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // RAM array carries no reset so it can map onto a memory macro.
    always_ff @(posedge clk) begin
        if (state == WRITE) mem[addr] <= wr_word;
    end

    // Status outputs are registered from the state, so they trail it by one cycle;
    // this lets pass include the mismatch found in the final CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            dout_a         <= '0;
            dout_b         <= '0;
            addr           <= '0;
            rd_addr        <= '0;
            rd_valid       <= 1'b0;
            mode_q         <= '0;
            inj_q          <= 1'b0;
            inj_addr_q     <= '0;
        end else begin
            busy     <= (state == WRITE || state == READ || state == CHECK);
            done     <= (state == DONE) && !accept;
            pass     <= (state == DONE) && !accept && (err_count == '0);
            rd_valid <= (state == READ);
            if (accept) begin
                mode_q         <= mode;
                inj_q          <= inject_en;
                inj_addr_q     <= inject_addr;
                addr           <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
            end
            if (state == WRITE) begin
                dout_a <= wr_word;
                addr   <= addr + 1'b1;
            end
            if (state == READ) begin
                dout_b  <= mem[addr];
                rd_addr <= addr;
                addr    <= addr + 1'b1;
            end
            if (mismatch) begin
                err_count <= err_count + 1'b1;
                if (err_count == '0) first_err_addr <= rd_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_bist.sv
// Directed table-driven bench for ram_bist: an 8x16 instance for most cases
// and a 16x64 instance for the wide-parameter boundary case.
module tb_ram_bist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic       inject_en = 1'b0;
    logic [3:0] inject_addr = '0;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_err_addr;
    logic [7:0] dout_a, dout_b;

    logic        w_start = 1'b0;
    logic [1:0]  w_mode = '0;
    logic        w_inj = 1'b0;
    logic [5:0]  w_inj_addr = '0;
    logic        w_busy, w_done, w_pass;
    logic [6:0]  w_err;
    logic [5:0]  w_first;
    logic [15:0] w_dout_a, w_dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bist #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .inject_en(inject_en),
        .inject_addr(inject_addr), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .dout_a(dout_a), .dout_b(dout_b)
    );

    ram_bist #(.DATA_W(16), .ADDR_W(6)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .mode(w_mode), .inject_en(w_inj),
        .inject_addr(w_inj_addr), .busy(w_busy), .done(w_done), .pass(w_pass),
        .err_count(w_err), .first_err_addr(w_first),
        .dout_a(w_dout_a), .dout_b(w_dout_b)
    );

    typedef struct {
        logic [1:0] mode;
        logic       inj;
        logic [3:0] inj_addr;
        logic [3:0] probe;
        logic [7:0] exp_word;
        logic       exp_pass;
        logic [4:0] exp_err;
        logic [3:0] exp_first;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Edge 0 is the edge that samples start; inputs are scrambled afterwards to
    // show they are latched only on the accepted start.
    task automatic run_small(input vec_t v, input bit glitch);
        @(negedge clk);
        mode = v.mode; inject_en = v.inj; inject_addr = v.inj_addr; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = ~v.mode; inject_en = ~v.inj; inject_addr = ~v.inj_addr;
        chk("done_clear", 32'(done), 0);
        for (int e = 1; e <= 34; e++) begin
            if (glitch) start = (e == 10);
            @(posedge clk); #1;
            if (e == 1) begin
                chk("busy_rise", 32'(busy), 1);
                chk("done_low", 32'(done), 0);
            end
            if (e == 1 + int'(v.probe))  chk("dout_a_probe", 32'(dout_a), 32'(v.exp_word));
            if (e == 17 + int'(v.probe)) chk("dout_b_probe", 32'(dout_b), 32'(v.exp_word));
            if (v.mode == 2'd0 && !v.inj && e >= 17 && e <= 32)
                chk("dout_b_seq", 32'(dout_b), 32'(e - 17));
            if (e == 33) begin
                chk("done_early", 32'(done), 0);
                chk("busy_check", 32'(busy), 1);
            end
            if (e == 34) begin
                chk("done_at_34", 32'(done), 1);
                chk("busy_fall", 32'(busy), 0);
                chk("pass", 32'(pass), 32'(v.exp_pass));
                chk("err_count", 32'(err_count), 32'(v.exp_err));
                chk("first_err_addr", 32'(first_err_addr), 32'(v.exp_first));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 1'b0, 4'd0,  4'd3,  8'h03, 1'b1, 5'd0, 4'd0};
        vecs[1] = '{2'd2, 1'b1, 4'd5,  4'd5,  8'hAB, 1'b0, 5'd1, 4'd5};
        vecs[2] = '{2'd3, 1'b0, 4'd0,  4'd9,  8'h02, 1'b1, 5'd0, 4'd0};
        vecs[3] = '{2'd3, 1'b0, 4'd0,  4'd7,  8'h80, 1'b1, 5'd0, 4'd0};
        vecs[4] = '{2'd1, 1'b0, 4'd0,  4'd3,  8'hFC, 1'b1, 5'd0, 4'd0};
        vecs[5] = '{2'd0, 1'b1, 4'd0,  4'd0,  8'h01, 1'b0, 5'd1, 4'd0};
        vecs[6] = '{2'd1, 1'b1, 4'd15, 4'd15, 8'hF1, 1'b0, 5'd1, 4'd15};
        vecs[7] = '{2'd2, 1'b0, 4'd0,  4'd4,  8'h55, 1'b1, 5'd0, 4'd0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_dout_b", 32'(dout_b), 0);
        @(negedge clk) rst = 1'b0;

        // Consecutive rows start from DONE, covering back-to-back re-runs.
        for (int i = 0; i < 8; i++) run_small(vecs[i], 1'b0);

        // Start pulses while busy must not disturb timing or results.
        run_small(vecs[0], 1'b1);
        run_small(vecs[1], 1'b1);

        // Asynchronous reset mid-WRITE, checked before any further clock edge.
        @(negedge clk);
        mode = 2'd0; inject_en = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("pre_rst_dout_a", 32'(dout_a), 7);
        #1 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_pass", 32'(pass), 0);
        chk("arst_err", 32'(err_count), 0);
        chk("arst_first", 32'(first_err_addr), 0);
        chk("arst_dout_a", 32'(dout_a), 0);
        chk("arst_dout_b", 32'(dout_b), 0);
        @(negedge clk) rst = 1'b0;
        run_small(vecs[0], 1'b0);

        // Wide instance: fault on the last address is only caught in the CHECK cycle.
        @(negedge clk);
        w_mode = 2'd0; w_inj = 1'b1; w_inj_addr = 6'd63; w_start = 1'b1;
        @(posedge clk); #1 w_start = 1'b0;
        for (int e = 1; e <= 130; e++) begin
            @(posedge clk); #1;
            if (e == 1)   chk("w_busy_rise", 32'(w_busy), 1);
            if (e == 64)  chk("w_dout_a_63", 32'(w_dout_a), 32'h3E);
            if (e == 128) chk("w_dout_b_63", 32'(w_dout_b), 32'h3E);
            if (e == 129) chk("w_done_early", 32'(w_done), 0);
            if (e == 130) begin
                chk("w_done_at_130", 32'(w_done), 1);
                chk("w_pass", 32'(w_pass), 0);
                chk("w_err_count", 32'(w_err), 1);
                chk("w_first_err", 32'(w_first), 63);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
